// File: rtl/latency_memory_if.sv
// Request/response bus between a CPU memory port and latency_memory.
// master drives the request side; slave returns resp and rdata.
interface latency_memory_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] wmask;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    resp;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output read, write, wmask, address, wdata,
        input  resp, rdata
    );

    modport slave (
        input  read, write, wmask, address, wdata,
        output resp, rdata
    );
endinterface

// File: rtl/latency_memory.sv
// Word-organised RAM that answers each read/write request after LATENCY cycles.
// Define LATENCY_MEMORY_STATS_EN to add the read_count/write_count output ports.
module latency_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    latency_memory_if.slave       bus
`ifdef LATENCY_MEMORY_STATS_EN
    ,
    output logic [31:0]           read_count,
    output logic [31:0]           write_count
`endif
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EXT_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]        wmask_q, wmask_d;
    logic                    is_wr_q, is_wr_d;
    logic                    resp_q, resp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
`ifdef LATENCY_MEMORY_STATS_EN
    logic [31:0]             read_count_q, read_count_d;
    logic [31:0]             write_count_q, write_count_d;
`endif

    logic                    req;
    logic                    enter_resp;
    logic                    mem_we;
    logic [EXT_W-1:0]        word_ext;
    logic [IDX_W-1:0]        word_idx;
    logic [DATA_WIDTH-1:0]   mem_array [DEPTH];

    assign req = bus.read | bus.write;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        is_wr_d    = is_wr_q;
        enter_resp = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = bus.address;
                    wdata_d = bus.wdata;
                    wmask_d = bus.wmask;
                    // a simultaneous read+write is treated as a write only
                    is_wr_d = bus.write;
                    cnt_d   = LAT_M1;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        resp_d = enter_resp;

        // Index from the value being latched so LATENCY==1 commits on the accept edge
        word_ext = EXT_W'(addr_d >> OFF_W);
        word_idx = IDX_W'(word_ext % EXT_W'(DEPTH));

        mem_we  = enter_resp & is_wr_d & rst_n;
        rdata_d = rdata_q;
        if (enter_resp && !is_wr_d) begin
            rdata_d = mem_array[word_idx];
        end

`ifdef LATENCY_MEMORY_STATS_EN
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (enter_resp) begin
            if (is_wr_d) begin
                write_count_d = write_count_q + 32'd1;
            end else begin
                read_count_d = read_count_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            is_wr_q       <= 1'b0;
            resp_q        <= 1'b0;
            rdata_q       <= '0;
`ifdef LATENCY_MEMORY_STATS_EN
            read_count_q  <= '0;
            write_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            is_wr_q       <= is_wr_d;
            resp_q        <= resp_d;
            rdata_q       <= rdata_d;
`ifdef LATENCY_MEMORY_STATS_EN
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
`endif
        end
    end

    // Array has no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wmask_d[b]) begin
                    mem_array[word_idx][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    assign bus.resp  = resp_q;
    assign bus.rdata = rdata_q;
`ifdef LATENCY_MEMORY_STATS_EN
    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`endif
endmodule
